data_memory_mmio: RTL and testbench

- MEM-stage data memory for the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Takes ALU_out as the address and rt data as the store data.
- Returns load data combinationally, so the MEM/WB register captures it at the same edge.
- Also hosts the memory-mapped peripherals:
  - a reloadable timer with interrupt request
  - LED and 7-segment display registers
  - an optional free-running systick counter

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_timer.sv | 67 ++++++
 rtl/data_memory_mmio.sv | 109 ++++++++++
 tb/tb_data_memory_mmio.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MEM-stage peripheral window: base address,
// register byte offsets and TCON bit positions.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h4000_0000;

  localparam logic [4:0]  OFF_TH      = 5'h00;
  localparam logic [4:0]  OFF_TL      = 5'h04;
  localparam logic [4:0]  OFF_TCON    = 5'h08;
  localparam logic [4:0]  OFF_LED     = 5'h0C;
  localparam logic [4:0]  OFF_DIGI    = 5'h10;
  localparam logic [4:0]  OFF_SYSTICK = 5'h14;

  localparam int unsigned TCON_W      = 3;
  localparam int unsigned TCON_EN     = 0;
  localparam int unsigned TCON_IE     = 1;
  localparam int unsigned TCON_IRQ    = 2;

endpackage

// File: rtl/mmio_timer.sv
// Reloadable timer (TH/TL/TCON) with level irq; CPU writes take priority
// over the same-cycle increment, reload or irq set.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_off,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  // Count/reload first, then let software writes override; reload reads old TH.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) tcon_d[TCON_IRQ] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wr_en) begin
      case (wr_off)
        OFF_TH:   th_d   = wr_data;
        OFF_TL:   tl_d   = wr_data;
        OFF_TCON: tcon_d = wr_data[TCON_W-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_off)
      OFF_TH:   rd_data = th_q;
      OFF_TL:   rd_data = tl_q;
      OFF_TCON: rd_data = 32'(tcon_q);
      default:  rd_data = '0;
    endcase
  end

  assign irq = tcon_q[TCON_IRQ];

endmodule

// File: rtl/data_memory_mmio.sv
// MEM-stage data RAM plus memory-mapped timer, LEDs and 7-segment registers.
// Define DATA_MEMORY_SYSTICK_EN to add a free-running systick counter at 0x14.
module data_memory_mmio #(
  parameter int unsigned RAM_DEPTH = 256,
  parameter logic [31:0] MMIO_BASE = mmio_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        irq
);
  import mmio_pkg::*;

  localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);
  localparam int unsigned RAM_BYTES = RAM_DEPTH * 4;

  logic [31:0]       ram_q [RAM_DEPTH];
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_hit, mmio_hit, mmio_we;
  logic [4:0]        off;
  logic [31:0]       timer_rdata, mmio_rdata;
  logic [7:0]        leds_q, leds_d;
  logic [11:0]       digi_q, digi_d;
  logic              unused_addr_bits;

  // Word access only: the byte lane bits never participate in decode.
  assign unused_addr_bits = ^Address[1:0];
  assign ram_idx  = Address[ADDR_W+1:2];
  assign ram_hit  = Address < 32'(RAM_BYTES);
  assign mmio_hit = Address[31:5] == MMIO_BASE[31:5];
  assign off      = {Address[4:2], 2'b00};
  assign mmio_we  = MemWrite && mmio_hit;

  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) ram_q[ram_idx] <= Write_data;
  end

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mmio_we),
    .wr_off  (off),
    .wr_data (Write_data),
    .rd_off  (off),
    .rd_data (timer_rdata),
    .irq     (irq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
      digi_q <= '0;
    end else begin
      leds_q <= leds_d;
      digi_q <= digi_d;
    end
  end

  always_comb begin
    leds_d = leds_q;
    digi_d = digi_q;
    if (mmio_we && off == OFF_LED)  leds_d = Write_data[7:0];
    if (mmio_we && off == OFF_DIGI) digi_d = Write_data[11:0];
  end

`ifdef DATA_MEMORY_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  always_ff @(posedge clk) begin
    if (reset) systick_q <= '0;
    else       systick_q <= systick_d;
  end

  always_comb begin
    systick_d = systick_q + 32'd1;
  end
`endif

  always_comb begin
    mmio_rdata = timer_rdata;
    case (off)
      OFF_LED:     mmio_rdata = 32'(leds_q);
      OFF_DIGI:    mmio_rdata = 32'(digi_q);
`ifdef DATA_MEMORY_SYSTICK_EN
      OFF_SYSTICK: mmio_rdata = systick_q;
`endif
      default:     ;
    endcase
  end

  // Reads are combinational and show pre-write contents on a same-cycle store.
  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (ram_hit)       Read_data = ram_q[ram_idx];
      else if (mmio_hit) Read_data = mmio_rdata;
    end
  end

  assign leds = leds_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed self-checking bench for data_memory_mmio (RAM, timer, LEDs, systick).
module tb_data_memory_mmio;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] MB = 32'h4000_0000;

  data_memory_mmio dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .leds       (leds),
    .digi       (digi),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemRead = 1'b0; MemWrite = 1'b1; Address = a; Write_data = d;
    step();
    idle();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemRead = 1'b1; MemWrite = 1'b0; Address = a;
    #1;
    chk(tag, Read_data, exp);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_digi", 32'(digi), 32'd0);
    chk("rst_rd_idle", Read_data, 32'd0);
    rd("rst_th", MB + 32'h00, 32'd0);
    rd("rst_tcon", MB + 32'h08, 32'd0);

    // RAM store then load
    wr(32'h10, 32'h1234_5678);
    rd("lw_0x10", 32'h10, 32'h1234_5678);
    MemRead = 1'b0; #1;
    chk("lw_noread", Read_data, 32'd0);
    rd("lw_byteoff", 32'h13, 32'h1234_5678);

    // Same-cycle write and read
    wr(32'h20, 32'h5);
    MemRead = 1'b1; MemWrite = 1'b1; Address = 32'h20; Write_data = 32'hAAAA_0000;
    #1;
    chk("rw_old", Read_data, 32'h5);
    step();
    MemWrite = 1'b0; #1;
    chk("rw_new", Read_data, 32'hAAAA_0000);
    idle();

    // Timer reload and irq
    wr(MB + 32'h00, 32'hFFFF_FFFC);
    wr(MB + 32'h04, 32'hFFFF_FFFE);
    wr(MB + 32'h08, 32'h3);
    rd("tl_start", MB + 32'h04, 32'hFFFF_FFFE);
    chk("irq_low0", 32'(irq), 32'd0);
    step(); #1;
    chk("tl_ffff", Read_data, 32'hFFFF_FFFF);
    chk("irq_low1", 32'(irq), 32'd0);
    step(); #1;
    chk("tl_reload", Read_data, 32'hFFFF_FFFC);
    chk("irq_set", 32'(irq), 32'd1);
    rd("tcon_irq", MB + 32'h08, 32'h7);
    wr(MB + 32'h08, 32'h3);
    #1;
    chk("irq_clr", 32'(irq), 32'd0);
    rd("tl_after_clr", MB + 32'h04, 32'hFFFF_FFFD);

    // TL write on overflow cycle wins; irq still set
    wr(MB + 32'h04, 32'hFFFF_FFFF);
    rd("tl_forced", MB + 32'h04, 32'hFFFF_FFFF);
    wr(MB + 32'h04, 32'h10);
    rd("tl_wr_wins", MB + 32'h04, 32'h10);
    chk("irq_ovf", 32'(irq), 32'd1);

    // TH write during reload: reload takes the old TH
    wr(MB + 32'h04, 32'hFFFF_FFFF);
    wr(MB + 32'h00, 32'h0000_0100);
    rd("tl_old_th", MB + 32'h04, 32'hFFFF_FFFC);
    rd("th_new", MB + 32'h00, 32'h0000_0100);

    // Out of range access and LED/digit registers
    rd("lw_miss", 32'h8000_0010, 32'd0);
    wr(32'h8000_0010, 32'hDEAD_BEEF);
    rd("miss_ram", 32'h10, 32'h1234_5678);
    rd("miss_th", MB + 32'h00, 32'h0000_0100);
    rd("miss_led", MB + 32'h0C, 32'd0);
    rd("gap_0x18", MB + 32'h18, 32'd0);
    wr(MB + 32'h0C, 32'h1A5);
    chk("leds_out", 32'(leds), 32'hA5);
    rd("leds_rd", MB + 32'h0C, 32'hA5);
    wr(MB + 32'h10, 32'h0000_FABC);
    chk("digi_out", 32'(digi), 32'hABC);
    rd("digi_rd", MB + 32'h10, 32'hABC);

    // Reset mid-count with irq pending
    idle();
    #1;
    chk("irq_pre_rst", 32'(irq), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst2_irq", 32'(irq), 32'd0);
    chk("rst2_leds", 32'(leds), 32'd0);
    chk("rst2_rd_idle", Read_data, 32'd0);
    rd("rst2_tl", MB + 32'h04, 32'd0);
    rd("rst2_tcon", MB + 32'h08, 32'd0);
    rd("rst2_ram", 32'h20, 32'hAAAA_0000);

`ifdef DATA_MEMORY_SYSTICK_EN
    rd("systick0", MB + 32'h14, 32'd0);
    step(); #1;
    chk("systick1", Read_data, 32'd1);
    wr(MB + 32'h14, 32'h55);
    rd("systick_nowr", MB + 32'h14, 32'd2);
`else
    rd("systick0", MB + 32'h14, 32'd0);
    step(); #1;
    chk("systick1", Read_data, 32'd0);
    wr(MB + 32'h14, 32'h55);
    rd("systick_nowr", MB + 32'h14, 32'd0);
`endif

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
